// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } add_state_t;

    function automatic int nchunk_of(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    // A single-chunk adder still needs a 1-bit counter to keep the port widths legal.
    function automatic int cnt_w_of(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, chained CHUNK-wide inside serial_adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle WIDTH-bit adder: CHUNK bits per clock through a full_adder ripple,
// with a registered inter-chunk carry and valid/ready handshakes on both sides.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NCHUNK = nchunk_of(WIDTH, CHUNK);
    localparam int CNT_W  = cnt_w_of(NCHUNK);

    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
        $error("serial_adder: need WIDTH >= 2, 1 <= CHUNK <= WIDTH and WIDTH a multiple of CHUNK");
    end

    add_state_t       state;
    add_state_t       state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_shifted;
    logic             carry_q;
    logic             co_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] chunk_sum;

    assign c[0] = carry_q;

    for (genvar i = 0; i < CHUNK; i++) begin : g_ripple
        full_adder u_fa (
            .a     (a_sh[i]),
            .b     (b_sh[i]),
            .c_in  (c[i]),
            .sum   (chunk_sum[i]),
            .c_out (c[i+1])
        );
    end

    assign last = (cnt == CNT_W'(NCHUNK - 1));

    // New chunk enters at the top; after NCHUNK shifts the first chunk sits in the low bits.
    assign sum_shifted = (sum_q >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= c_in;
                        cnt     <= '0;
                    end
                end
                BUSY: begin
                    a_sh    <= a_sh >> CHUNK;
                    b_sh    <= b_sh >> CHUNK;
                    sum_q   <= sum_shifted;
                    carry_q <= c[CHUNK];
                    cnt     <= cnt + 1'b1;
                    // On the last chunk the top cell is bit WIDTH-1, so c[CHUNK-1] is the carry into the MSB.
                    if (last) begin
                        co_q  <= c[CHUNK];
                        ovf_q <= c[CHUNK-1] ^ c[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum   = sum_q;
    assign c_out = co_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit/2-bit-chunk instance plus exhaustive 4-bit sweeps.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid, in_ready, out_valid, out_ready, c_in, c_out, ovf;
    logic [7:0] a, b, sum;

    logic       in_valid4, out_ready4, cin4;
    logic [3:0] a4, b4;
    logic       rdy_c1, vld_c1, co_c1, ovf_c1;
    logic       rdy_c2, vld_c2, co_c2, ovf_c2;
    logic       rdy_c4, vld_c4, co_c4, ovf_c4;
    logic [3:0] sum_c1, sum_c2, sum_c4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .CHUNK(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    serial_adder #(.WIDTH(4), .CHUNK(1)) u_w4c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(rdy_c1),
        .a(a4), .b(b4), .c_in(cin4), .out_valid(vld_c1), .out_ready(out_ready4),
        .sum(sum_c1), .c_out(co_c1), .ovf(ovf_c1)
    );

    serial_adder #(.WIDTH(4), .CHUNK(2)) u_w4c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(rdy_c2),
        .a(a4), .b(b4), .c_in(cin4), .out_valid(vld_c2), .out_ready(out_ready4),
        .sum(sum_c2), .c_out(co_c2), .ovf(ovf_c2)
    );

    serial_adder #(.WIDTH(4), .CHUNK(4)) u_w4c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(rdy_c4),
        .a(a4), .b(b4), .c_in(cin4), .out_valid(vld_c4), .out_ready(out_ready4),
        .sum(sum_c4), .c_out(co_c4), .ovf(ovf_c4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        a = ta; b = tb; c_in = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic release8();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_hs", out_valid, 0);
        check("in_ready_after_hs", in_ready, 1);
    endtask

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic eco, input logic eov);
        int lat;
        start8(ta, tb, tc, lat);
        check("latency8", lat, 4);
        check("sum8", sum, es);
        check("cout8", c_out, eco);
        check("ovf8", ovf, eov);
        release8();
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        int lat1, lat2, lat4, sa, sb, r;
        logic [4:0] exp;
        logic eov;
        lat1 = -1; lat2 = -1; lat4 = -1;
        exp = 5'(ta) + 5'(tb) + 5'(tc);
        sa  = ta[3] ? int'(ta) - 16 : int'(ta);
        sb  = tb[3] ? int'(tb) - 16 : int'(tb);
        r   = sa + sb + int'(tc);
        eov = (r > 7) || (r < -8);
        check("w4_in_ready", {rdy_c1, rdy_c2, rdy_c4}, 3'b111);
        a4 = ta; b4 = tb; cin4 = tc; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (vld_c1 && lat1 < 0) lat1 = n;
            if (vld_c2 && lat2 < 0) lat2 = n;
            if (vld_c4 && lat4 < 0) lat4 = n;
            if (lat1 >= 0 && lat2 >= 0 && lat4 >= 0) break;
        end
        check("w4c1_latency", lat1, 4);
        check("w4c2_latency", lat2, 2);
        check("w4c4_latency", lat4, 1);
        check("w4c1_result", {co_c1, sum_c1}, exp);
        check("w4c2_result", {co_c2, sum_c2}, exp);
        check("w4c4_result", {co_c4, sum_c4}, exp);
        check("w4c1_ovf", ovf_c1, eov);
        check("w4c2_ovf", ovf_c2, eov);
        check("w4c4_ovf", ovf_c4, eov);
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        rst = 1'b1;
        tick(); tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", c_out, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick();
        check("rst_in_ready", in_ready, 1);

        run8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        run8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Reset asserted while a result is pending: clears immediately, no edge needed.
        start8(8'h5A, 8'h3C, 1'b0, lat);
        check("pre_rst_sum", sum, 8'h96);
        rst = 1'b1;
        #1;
        check("async_rst_sum", sum, 8'h00);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_ovf", ovf, 0);
        tick(); tick(); tick();
        check("midrun_rst_sum", sum, 8'h00);
        check("midrun_rst_cout", c_out, 0);
        check("midrun_rst_ovf", ovf, 0);
        check("midrun_rst_out_valid", out_valid, 0);
        rst = 1'b0;
        tick();
        check("midrun_rst_in_ready", in_ready, 1);

        // Abort two cycles into BUSY.
        a = 8'h77; b = 8'h11; c_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_out_valid", seen, 0);
        run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // Backpressure with ignored requests.
        start8(8'h5A, 8'h3C, 1'b0, lat);
        check("bp_latency", lat, 4);
        for (int i = 0; i < 5; i++) begin
            a = 8'h11; b = 8'h22; c_in = 1'b0;
            in_valid = (i % 2 == 0);
            tick();
            check("bp_sum", sum, 8'h96);
            check("bp_cout", c_out, 0);
            check("bp_ovf", ovf, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        release8();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("bp_no_pending", seen, 0);
        run8(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                for (int k = 0; k < 2; k++)
                    run4(4'(i), 4'(j), 1'(k));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder that adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock, using a chain of CHUNK `full_adder` cells and a registered inter-chunk carry. It is the sequential, handshaked successor to the single-bit `full_adder`. It is used wherever a wide add must trade latency for area. Operands enter and results leave over valid/ready handshakes, and it reports unsigned carry-out and two's-complement overflow.

## Interface
- WIDTH, 8, operand and sum width; WIDTH ≥ 2; WIDTH must be a multiple of CHUNK
- CHUNK, 2, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH; NCHUNK = WIDTH/CHUNK
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  (a + b + c_in) mod 2^WIDTH
- c_out  output  1  unsigned carry-out of bit WIDTH-1
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- FSM states are IDLE, BUSY and DONE.
- Reset (asynchronous, immediate):
  - state = IDLE; out_valid = 0; sum = 0; c_out = 0; ovf = 0; shift registers and counter = 0.
  - in_ready = 1 once rst deasserts. No input is captured while rst is high.
- IDLE:
  - in_ready = 1.
  - On a clock edge with in_valid = 1: capture a, b and c_in into the A/B shift registers and the carry register, set the chunk counter to 0, and go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle, add the low CHUNK bits of the A and B shift registers plus the carry register through CHUNK chained `full_adder` cells.
  - Shift the CHUNK result bits into the top of the sum register (LSB chunk first, so it ends up in the low bits).
  - Shift A and B right by CHUNK, store the chunk carry-out, and increment the counter.
  - On the edge where counter == NCHUNK-1, also latch c_out (final carry) and ovf (carry into bit WIDTH-1 XOR final carry), then go to DONE.
- DONE:
  - out_valid = 1; in_ready = 0.
  - sum, c_out and ovf are stable.
  - On an edge with out_ready = 1, go to IDLE.
- The block does not accept new operands on the same edge a result is consumed. in_ready rises the cycle after the handshake completes.
- in_valid pulses are ignored while in BUSY or DONE. The block does not latch a pending request.
- sum, c_out and ovf hold the last result in IDLE. They are meaningful only while out_valid = 1.
- Reset asserted mid-operation (BUSY or DONE) aborts the operation. No out_valid is produced for the aborted operands.
- CHUNK == WIDTH degenerates to single-cycle BUSY. Behaviour is otherwise identical.

## Timing
- Input accept occurs at the edge where in_valid && in_ready.
- out_valid rises exactly NCHUNK edges after the accept edge. Latency = NCHUNK cycles.
- The output handshake completes at the edge where out_valid && out_ready. out_valid falls after that edge.
- Maximum throughput is one result per NCHUNK + 2 cycles.
- in_ready and out_valid are decoded from the registered state only, with no combinational path from in_valid or out_ready.
- The critical path is a CHUNK-bit ripple carry plus the shift-register mux.

## Structure
- Package `adder_pkg`:
  - state typedef `add_state_t` (IDLE, BUSY, DONE)
  - localparam function computing NCHUNK and the counter width, $clog2(NCHUNK) with a minimum of 1
- Sub-module: the existing `full_adder` (a, b, c_in → sum, c_out), instantiated CHUNK times in a generate loop to form the chunk ripple.
- Elaboration-time check: fail if WIDTH % CHUNK != 0 or CHUNK < 1.

## Test plan
- Reset: assert rst for 3 cycles mid-run → out_valid = 0, sum = 0x00, c_out = 0, ovf = 0; in_ready = 1 after release.
- WIDTH=8, CHUNK=2: a=0x5A, b=0x3C, c_in=0 → sum=0x96, c_out=0, ovf=1; out_valid rises exactly 4 cycles after accept.
- Full carry ripple across chunks: a=0xFF, b=0x00, c_in=1 → sum=0x00, c_out=1, ovf=0. Also a=0x80, b=0x80, c_in=0 → sum=0x00, c_out=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → sum, c_out and ovf stay stable, in_ready=0, and in_valid pulses (a=0x11, b=0x22) are ignored. The next result after release is for the new request only.
- Reset mid-operation: assert rst 2 cycles into BUSY → no out_valid. A following a=0x01, b=0x01, c_in=0 gives sum=0x02.
- Parameter sweep: WIDTH=4 with CHUNK=1, 2 and 4; exhaustive a, b and c_in → {c_out, sum} == a + b + c_in. Latency is 4, 2 and 1 cycles respectively.
